// File: rtl/mul_exu_ctrl.sv
// Purpose : Issue/writeback sequencer between the integer pipe and an external multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Latency : a zero operand gives a result 1 cycle after accept; otherwise 1 (issue) + multiplier latency + 1 (capture).
// Backpres: one op in flight; in_ready only in IDLE; issue waits on mul_out_ready; the result is held in DONE until out_ready.
//
// Ports:
//   clock, reset                        : single clock, synchronous active-high reset
//   in_valid/in_ready, in_op, in_word,
//   in_rs1, in_rs2, in_rd               : upstream issue handshake and operands
//   flush                               : cancel the op in flight
//   mul_in_valid, mul_flush, mul_mulw,
//   mul_signed, mul_multiplicand,
//   mul_multiplier                      : request to the multiplier
//   mul_out_ready, mul_out_valid,
//   mul_result_hi, mul_result_lo        : multiplier status and response
//   out_valid/out_ready, out_data,
//   out_rd                              : writeback handshake
module mul_exu_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic        in_word,
  input  logic [63:0] in_rs1,
  input  logic [63:0] in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        mul_in_valid,
  output logic        mul_flush,
  output logic        mul_mulw,
  output logic [1:0]  mul_signed,
  output logic [63:0] mul_multiplicand,
  output logic [63:0] mul_multiplier,
  input  logic        mul_out_ready,
  input  logic        mul_out_valid,
  input  logic [63:0] mul_result_hi,
  input  logic [63:0] mul_result_lo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd
);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic        word_q;
  logic [4:0]  rd_q;
  logic [63:0] mcand_q;
  logic [63:0] mplier_q;
  logic [1:0]  signed_q;
  logic [63:0] result_q;

  logic [63:0] prep_a;
  logic [63:0] prep_b;
  logic        prep_zero;
  logic [1:0]  prep_signed;
  logic        accept;
  logic [63:0] res_sel;

  // Operand preparation: word ops work on the sign-extended low halves.
  always_comb begin
    prep_a = in_rs1;
    prep_b = in_rs2;
    if (in_word) begin
      prep_a = {{32{in_rs1[31]}}, in_rs1[31:0]};
      prep_b = {{32{in_rs2[31]}}, in_rs2[31:0]};
    end
  end

  assign prep_zero = (prep_a == 64'd0) || (prep_b == 64'd0);

  // {multiplicand signed, multiplier signed}; MULW shares the MUL encoding.
  always_comb begin
    prep_signed = 2'b11;
    case (in_op)
      OP_MULHSU: prep_signed = 2'b10;
      OP_MULHU:  prep_signed = 2'b00;
      default:   prep_signed = 2'b11;
    endcase
  end

  // A flush in IDLE drops in_ready so that no accept can happen that cycle.
  assign in_ready = (state == S_IDLE) && !flush && !reset;
  assign accept   = in_valid && in_ready;

  // Result selection from the multiplier response.
  always_comb begin
    res_sel = mul_result_hi;
    if (op_q == OP_MUL) begin
      if (word_q) begin
        res_sel = {{32{mul_result_lo[31]}}, mul_result_lo[31:0]};
      end else begin
        res_sel = mul_result_lo;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_MUL;
      word_q   <= 1'b0;
      rd_q     <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 64'd0;
      signed_q <= 2'b00;
      result_q <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= in_op;
            word_q   <= in_word;
            rd_q     <= in_rd;
            mcand_q  <= prep_a;
            mplier_q <= prep_b;
            signed_q <= prep_signed;
            result_q <= 64'd0;
            state    <= prep_zero ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (mul_out_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            // A response arriving in the flush cycle is already consumed,
            // so there is nothing left to drain.
            state <= mul_out_valid ? S_IDLE : S_DRAIN;
          end else if (mul_out_valid) begin
            result_q <= res_sel;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush) begin
            result_q <= 64'd0;
            state    <= S_IDLE;
          end else if (out_ready) begin
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mul_out_valid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced to their idle values while reset is high, since the
  // synchronous clear only lands at the next edge.
  assign mul_in_valid     = (state == S_ISSUE) && mul_out_ready && !flush && !reset;
  assign mul_flush        = (state == S_WAIT) && flush && !reset;
  assign mul_mulw         = reset ? 1'b0 : word_q;
  assign mul_signed       = reset ? 2'b00 : signed_q;
  assign mul_multiplicand = reset ? 64'd0 : mcand_q;
  assign mul_multiplier   = reset ? 64'd0 : mplier_q;

  assign out_valid = (state == S_DONE) && !reset;
  assign out_data  = out_valid ? result_q : 64'd0;
  assign out_rd    = out_valid ? rd_q : 5'd0;

endmodule

// File: tb/tb_mul_exu_ctrl.sv
// Purpose : Self-checking bench for mul_exu_ctrl with a behavioural 34-cycle multiplier.
// Latency : expects 36 cycles accept->out_valid for real ops, 1 cycle for zero-operand ops.
// Backpres: exercises out_ready hold, flush in ISSUE/WAIT/DONE/DRAIN and reset mid-op.
module tb_mul_exu_ctrl;

  localparam int L = 34;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_word;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        mul_in_valid;
  logic        mul_flush;
  logic        mul_mulw;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand;
  logic [63:0] mul_multiplier;
  logic        mul_out_ready;
  logic        mul_out_valid;
  logic [63:0] mul_result_hi;
  logic [63:0] mul_result_lo;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;

  always #5 clock = ~clock;

  mul_exu_ctrl dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
    .mul_in_valid(mul_in_valid), .mul_flush(mul_flush), .mul_mulw(mul_mulw),
    .mul_signed(mul_signed), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_out_ready(mul_out_ready), .mul_out_valid(mul_out_valid),
    .mul_result_hi(mul_result_hi), .mul_result_lo(mul_result_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural multiplier ----------------
  logic         busy = 1'b0;
  int           cnt;
  logic         start;
  logic [63:0]  sa, sb;
  logic [1:0]   ssg;
  logic [127:0] prod;

  function automatic logic [127:0] model_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sg);
    logic [127:0] xa, xb;
    xa = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
    xb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return xa * xb;
  endfunction

  assign mul_out_ready = !busy;

  // Response appears L cycles after the cycle mul_in_valid was high; flush is
  // not honoured, so a flushed op still returns a late response.
  initial begin
    mul_out_valid = 1'b0;
    mul_result_hi = 64'd0;
    mul_result_lo = 64'd0;
    forever begin
      @(negedge clock);
      start = mul_in_valid;
      sa    = mul_multiplicand;
      sb    = mul_multiplier;
      ssg   = mul_signed;
      @(posedge clock);
      #1;
      if (mul_out_valid) begin
        mul_out_valid = 1'b0;
        busy          = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          mul_out_valid = 1'b1;
          {mul_result_hi, mul_result_lo} = prod;
        end
      end
      if (start) begin
        busy = 1'b1;
        cnt  = L - 1;
        prod = model_mul(sa, sb, ssg);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb_q[$];

  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_lat = -1;
  int   n_issue = 0;
  int   n_mflush = 0;
  int   n_out = 0;
  logic prev_ov = 1'b0;

  initial forever @(posedge clock) cyc++;

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (in_valid && in_ready) acc_cyc = cyc;
        if (out_valid && !prev_ov) last_lat = cyc - acc_cyc;
        if (mul_in_valid) n_issue++;
        if (mul_flush) n_mflush++;
        if (out_valid) n_out++;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_out", {63'd0, out_valid}, 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- reference ----------------
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  p64;
    logic [127:0] p;
    p64 = a * b;
    if (word) return {{32{p64[31]}}, p64[31:0]};
    case (op)
      2'd0:    return p64;
      2'd1:    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
      2'd2:    p = {{64{a[63]}}, a} * {64'd0, b};
      default: p = {64'd0, a} * {64'd0, b};
    endcase
    return p[127:64];
  endfunction

  function automatic logic [63:0] prep(input logic word, input logic [63:0] v);
    return word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic drive_accept(input logic [1:0] op, input logic word, input logic [63:0] rs1,
                              input logic [63:0] rs2, input logic [4:0] rd, input bit push);
    exp_t e;
    wait_ready();
    in_valid = 1'b1;
    in_op    = op;
    in_word  = word;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    if (push) begin
      e.data = ref_result(op, word, rs1, rs2);
      e.rd   = rd;
      sb_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic word, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [4:0] rd);
    logic [63:0] a, b;
    logic [1:0]  sg;
    bit          zero;
    int          n0, bad, n;
    a    = prep(word, rs1);
    b    = prep(word, rs2);
    zero = (a == 64'd0) || (b == 64'd0);
    sg   = (op == 2'd2) ? 2'b10 : (op == 2'd3) ? 2'b00 : 2'b11;
    n0   = n_issue;
    drive_accept(op, word, rs1, rs2, rd, 1'b1);
    if (!zero) begin
      chk("mul_in_valid", {63'd0, mul_in_valid}, 64'd1);
      chk("mul_signed", {62'd0, mul_signed}, {62'd0, sg});
      chk("mul_mulw", {63'd0, mul_mulw}, {63'd0, word});
      chk("mul_multiplicand", mul_multiplicand, a);
      chk("mul_multiplier", mul_multiplier, b);
      tick();
      chk("mul_in_valid_one_cycle", {63'd0, mul_in_valid}, 64'd0);
      bad = 0;
      n   = 0;
      while (!out_valid && n < 100) begin
        if (mul_multiplicand !== a || mul_multiplier !== b || mul_signed !== sg) bad++;
        tick();
        n++;
      end
      chk("operands_stable", bad, 0);
    end
    chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
    tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("latency", last_lat, zero ? 1 : L + 2);
    if (zero) chk("zero_no_issue", n_issue - n0, 0);
    else      chk("one_issue", n_issue - n0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mul_in_valid"}, {63'd0, mul_in_valid}, 64'd0);
    chk({tag, "_mul_flush"}, {63'd0, mul_flush}, 64'd0);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_rd"}, {59'd0, out_rd}, 64'd0);
    chk({tag, "_mul_signed"}, {62'd0, mul_signed}, 64'd0);
    chk({tag, "_mul_mulw"}, {63'd0, mul_mulw}, 64'd0);
    chk({tag, "_mcand"}, mul_multiplicand, 64'd0);
    chk({tag, "_mplier"}, mul_multiplier, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int bad, n, o0, m0, i0;
    reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_word = 1'b0;
    in_rs1 = 64'd0; in_rs2 = 64'd0; in_rd = 5'd0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk_reset_outputs("in_reset");
    reset = 1'b0;
    #1;
    chk_reset_outputs("post_reset");
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed ops
    do_op(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1);           // MULH  -> all ones
    do_op(2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2); // MULHU
    do_op(2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'd2, 5'd3);           // MULW -> 0
    do_op(2'd0, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 5'd4);           // MULW -> sext
    do_op(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5);           // MULHSU signed rs1
    do_op(2'd2, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6);           // MULHSU unsigned rs2
    do_op(2'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd8);
    do_op(2'd0, 1'b1, 64'h0000_0001_0000_0000, 64'd5, 5'd9);           // MULW low half zero

    // Zero shortcut with writeback backpressure
    out_ready = 1'b0;
    i0 = n_issue;
    drive_accept(2'd0, 1'b0, 64'd9, 64'd0, 5'd7, 1'b1);
    chk("zero_out_valid", {63'd0, out_valid}, 64'd1);
    chk("zero_out_data", out_data, 64'd0);
    chk("zero_out_rd", {59'd0, out_rd}, 64'd7);
    bad = 0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 64'd0 || out_rd !== 5'd7) bad++;
    end
    chk("zero_hold_stable", bad, 0);
    out_ready = 1'b1;
    tick();
    chk("zero_drained", sb_q.size(), 0);
    chk("zero_latency", last_lat, 1);
    chk("zero_no_issue", n_issue - i0, 0);

    // Flush in ISSUE suppresses the request
    i0 = n_issue;
    drive_accept(2'd0, 1'b0, 64'd3, 64'd4, 5'd10, 1'b0);
    flush = 1'b1;
    #1;
    chk("issue_flush_no_req", {63'd0, mul_in_valid}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("issue_flush_idle", {63'd0, in_ready}, 64'd1);
    chk("issue_flush_no_out", {63'd0, out_valid}, 64'd0);
    chk("issue_flush_no_issue", n_issue - i0, 0);

    // Flush in DONE discards the result
    out_ready = 1'b0;
    drive_accept(2'd0, 1'b0, 64'd0, 64'd4, 5'd11, 1'b0);
    chk("done_before_flush", {63'd0, out_valid}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("done_flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("done_flush_out_rd", {59'd0, out_rd}, 64'd0);
    chk("done_flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;

    // Flush in WAIT -> DRAIN until the late response
    o0 = n_out;
    m0 = n_mflush;
    drive_accept(2'd0, 1'b0, 64'd7, 64'd9, 5'd12, 1'b0);
    tick();
    repeat (10) tick();
    flush = 1'b1;
    #1;
    chk("wait_flush_pulse", {63'd0, mul_flush}, 64'd1);
    tick();
    #1;
    chk("wait_flush_one_cycle", {63'd0, mul_flush}, 64'd0);
    chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    #1;
    chk("drain_flush_ignored", {63'd0, mul_flush}, 64'd0);
    tick();
    flush = 1'b0;
    bad = 0;
    n   = 0;
    while (!mul_out_valid && n < 100) begin
      if (in_ready) bad++;
      tick();
      n++;
    end
    chk("drain_ready_low", bad, 0);
    chk("late_response_seen", {63'd0, mul_out_valid}, 64'd1);
    chk("drain_ready_at_resp", {63'd0, in_ready}, 64'd0);
    tick();
    chk("drain_exit_ready", {63'd0, in_ready}, 64'd1);
    chk("mul_flush_count", n_mflush - m0, 1);
    chk("flush_no_out", n_out - o0, 0);
    do_op(2'd0, 1'b0, 64'd3, 64'd5, 5'd13);

    // Reset in WAIT, with a flush attempt overridden by reset
    o0 = n_out;
    drive_accept(2'd0, 1'b0, 64'd6, 64'd7, 5'd14, 1'b0);
    repeat (6) tick();
    reset = 1'b1;
    flush = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    tick();
    reset = 1'b0;
    flush = 1'b0;
    #1;
    chk_reset_outputs("after_mid_reset");
    chk("after_mid_reset_in_ready", {63'd0, in_ready}, 64'd1);
    n = 0;
    while (!mul_out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("stray_response_seen", {63'd0, mul_out_valid}, 64'd1);
    tick();
    tick();
    chk("stray_no_out", n_out - o0, 0);
    chk("stray_in_ready", {63'd0, in_ready}, 64'd1);

    // A few random ops after recovery
    for (int k = 0; k < 4; k++) begin
      do_op(2'($urandom_range(0, 3)), 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom_range(1, 31)));
    end
    do_op(2'd0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
